mem_arbiter: RTL and testbench

- Shares one single-ported backing memory between the instruction-fetch port and the data-memory port of the pipelined CPU.
- Each requester holds a level request and stalls its pipeline while `req && !ready`.
- The arbiter grants one access at a time, sequences a fixed-latency memory access, and returns read data with a one-cycle ready pulse.
- Data accesses have priority; a starvation limit guarantees instruction fetch progress.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and backing-memory signals shared by the arbiter.
// The master side is the CPU plus memory model; the slave side is the arbiter.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;

    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;

    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport master (
        output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  mem_enable, mem_rw, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ready, d_rdata, d_ready,
        output mem_enable, mem_rw, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one fixed-latency memory.
// Data has priority; a starvation counter forces a fetch grant after FAIR_LIMIT data grants.
module mem_arbiter #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FAIR_LIMIT = 4
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned FairW = $clog2(FAIR_LIMIT + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
    typedef enum logic {OwnI, OwnD} owner_e;

    state_e            state_q;
    owner_e            owner_q;
    logic [CntW-1:0]   cnt_q;
    logic [FairW-1:0]  fair_cnt_q;
    logic              mem_enable_q;
    logic              mem_rw_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              i_ready_q;
    logic              d_ready_q;
    logic              busy_q;

    logic fair_hit;
    logic grant_d;
    logic grant_i;

    // A pending fetch that has waited FAIR_LIMIT data grants wins over data.
    assign fair_hit = bus.i_req && (fair_cnt_q == FairW'(FAIR_LIMIT));
    assign grant_d  = bus.d_req && !fair_hit;
    assign grant_i  = !grant_d && bus.i_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= OwnI;
            cnt_q        <= '0;
            fair_cnt_q   <= '0;
            mem_enable_q <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_d || grant_i) begin
                        state_q      <= StAccess;
                        cnt_q        <= CntW'(LATENCY - 1);
                        mem_enable_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                    if (grant_d) begin
                        owner_q     <= OwnD;
                        mem_addr_q  <= bus.d_addr;
                        mem_rw_q    <= bus.d_rw;
                        mem_wdata_q <= bus.d_wdata;
                        if (!bus.i_req) begin
                            fair_cnt_q <= '0;
                        end else if (fair_cnt_q != FairW'(FAIR_LIMIT)) begin
                            fair_cnt_q <= fair_cnt_q + 1'b1;
                        end
                    end else if (grant_i) begin
                        owner_q    <= OwnI;
                        mem_addr_q <= bus.i_addr;
                        mem_rw_q   <= 1'b1;
                        fair_cnt_q <= '0;
                    end
                end
                StAccess: begin
                    if (cnt_q == '0) begin
                        if (mem_rw_q) begin
                            if (owner_q == OwnD) begin
                                d_rdata_q <= bus.mem_rdata;
                            end else begin
                                i_rdata_q <= bus.mem_rdata;
                            end
                        end
                        state_q      <= StResp;
                        mem_enable_q <= 1'b0;
                        i_ready_q    <= (owner_q == OwnI);
                        d_ready_q    <= (owner_q == OwnD);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    // Mandatory bubble: a requester dropping req after ready is never re-granted.
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q      <= StIdle;
                    mem_enable_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_enable = mem_enable_q;
    assign bus.mem_rw     = mem_rw_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.i_ready    = i_ready_q;
    assign bus.d_ready    = d_ready_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A (LATENCY=2, FAIR_LIMIT=4), instance B (LATENCY=1).
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    mem_arbiter_if ifa();
    mem_arbiter_if ifb();

    mem_arbiter #(.LATENCY(2), .FAIR_LIMIT(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    mem_arbiter #(.LATENCY(1), .FAIR_LIMIT(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        clk   = 1'b0;
        reset = 1'b1;
        ifa.i_req = 0; ifa.i_addr = 0; ifa.d_req = 0; ifa.d_rw = 0;
        ifa.d_addr = 0; ifa.d_wdata = 0; ifa.mem_rdata = 0;
        ifb.i_req = 0; ifb.i_addr = 0; ifb.d_req = 0; ifb.d_rw = 0;
        ifb.d_addr = 0; ifb.d_wdata = 0; ifb.mem_rdata = 0;

        // Reset state
        tick(); tick();
        chk("rst_mem_enable", ifa.mem_enable, 1'b0);
        chk("rst_busy", ifa.busy, 1'b0);
        chk("rst_ready", {ifa.i_ready, ifa.d_ready}, 2'b00);
        chk("rst_mem_bus", {ifa.mem_rw, ifa.mem_addr, ifa.mem_wdata} == '0, 1'b1);
        chk("rst_rdata", {ifa.i_rdata, ifa.d_rdata} == '0, 1'b1);
        reset = 1'b0;
        tick();

        // Single fetch
        ifa.i_req = 1; ifa.i_addr = 32'h40; ifa.mem_rdata = 32'h8C01_0004;
        tick();
        chk("t1_en_c1", ifa.mem_enable, 1'b1);
        chk("t1_addr", ifa.mem_addr, 32'h40);
        chk("t1_rw", ifa.mem_rw, 1'b1);
        chk("t1_busy", ifa.busy, 1'b1);
        tick();
        chk("t1_en_c2", ifa.mem_enable, 1'b1);
        chk("t1_no_early_ready", ifa.i_ready, 1'b0);
        tick();
        chk("t1_en_off", ifa.mem_enable, 1'b0);
        chk("t1_ready", {ifa.i_ready, ifa.d_ready}, 2'b10);
        chk("t1_rdata", ifa.i_rdata, 32'h8C01_0004);
        ifa.i_req = 0; ifa.mem_rdata = 32'hFFFF_0000;
        tick();
        chk("t1_ready_pulse", ifa.i_ready, 1'b0);
        chk("t1_busy_off", ifa.busy, 1'b0);
        tick();
        chk("t1_rdata_held", ifa.i_rdata, 32'h8C01_0004);
        chk("t1_idle_en", ifa.mem_enable, 1'b0);

        // Data read, then data write that must leave d_rdata alone
        ifa.d_req = 1; ifa.d_rw = 1; ifa.d_addr = 32'h104; ifa.mem_rdata = 32'hCAFE_F00D;
        tick(); tick(); tick();
        chk("t2_rd_ready", {ifa.i_ready, ifa.d_ready}, 2'b01);
        chk("t2_rd_rdata", ifa.d_rdata, 32'hCAFE_F00D);
        ifa.d_req = 0;
        tick();
        ifa.d_req = 1; ifa.d_rw = 0; ifa.d_addr = 32'h100; ifa.d_wdata = 32'hDEAD_BEEF;
        ifa.mem_rdata = 32'h1234_5678;
        tick();
        chk("t2_wr_rw", ifa.mem_rw, 1'b0);
        chk("t2_wr_wdata", ifa.mem_wdata, 32'hDEAD_BEEF);
        chk("t2_wr_addr", ifa.mem_addr, 32'h100);
        ifa.d_addr = 32'h200; ifa.d_wdata = 32'h0;
        tick();
        chk("t2_wr_wdata_stable", ifa.mem_wdata, 32'hDEAD_BEEF);
        chk("t2_wr_addr_stable", ifa.mem_addr, 32'h100);
        tick();
        chk("t2_wr_ready", ifa.d_ready, 1'b1);
        chk("t2_wr_rdata_kept", ifa.d_rdata, 32'hCAFE_F00D);
        ifa.d_req = 0;
        tick();
        chk("t2_wr_ready_pulse", ifa.d_ready, 1'b0);

        // Simultaneous requests: D first, I four cycles later
        ifa.i_req = 1; ifa.i_addr = 32'h80;
        ifa.d_req = 1; ifa.d_rw = 1; ifa.d_addr = 32'h200; ifa.mem_rdata = 32'h0D0D_0D0D;
        tick();
        chk("t3_first_d", ifa.mem_addr, 32'h200);
        tick(); tick();
        chk("t3_d_ready", {ifa.i_ready, ifa.d_ready}, 2'b01);
        chk("t3_d_rdata", ifa.d_rdata, 32'h0D0D_0D0D);
        ifa.d_req = 0; ifa.mem_rdata = 32'h1F1F_1F1F;
        tick();
        chk("t3_bubble", {ifa.mem_enable, ifa.i_ready, ifa.d_ready}, 3'b000);
        tick();
        chk("t3_i_grant_en", ifa.mem_enable, 1'b1);
        chk("t3_i_grant_addr", ifa.mem_addr, 32'h80);
        tick(); tick();
        chk("t3_i_ready", {ifa.i_ready, ifa.d_ready}, 2'b10);
        chk("t3_i_rdata", ifa.i_rdata, 32'h1F1F_1F1F);
        ifa.i_req = 0;
        tick();

        // Starvation: both held, expect D,D,D,D,I,D,D,D,D,I
        ifa.i_req = 1; ifa.i_addr = 32'h300;
        ifa.d_req = 1; ifa.d_rw = 1; ifa.d_addr = 32'h400;
        for (int g = 0; g < 10; g++) begin
            tick();
            chk($sformatf("t4_grant%0d", g), ifa.mem_addr, (g % 5 == 4) ? 32'h300 : 32'h400);
            tick(); tick();
            chk($sformatf("t4_ready%0d", g), {ifa.i_ready, ifa.d_ready},
                (g % 5 == 4) ? 32'd2 : 32'd1);
            tick();
        end
        ifa.i_req = 0; ifa.d_req = 0;
        tick();
        chk("t4_idle", ifa.busy, 1'b0);

        // Reset in the 2nd ACCESS cycle
        ifa.d_req = 1; ifa.d_rw = 1; ifa.d_addr = 32'h500; ifa.mem_rdata = 32'h55;
        tick(); tick();
        chk("t5_in_access", ifa.mem_enable, 1'b1);
        reset = 1'b1; ifa.d_req = 0;
        #1;
        chk("t5_en_async", ifa.mem_enable, 1'b0);
        chk("t5_busy_async", ifa.busy, 1'b0);
        chk("t5_ready_async", {ifa.i_ready, ifa.d_ready}, 2'b00);
        tick();
        reset = 1'b0;
        tick();
        chk("t5_no_ready", {ifa.i_ready, ifa.d_ready}, 2'b00);
        chk("t5_rdata_cleared", ifa.d_rdata, 32'h0);
        tick();
        chk("t5_stay_idle", {ifa.busy, ifa.mem_enable}, 2'b00);
        ifa.i_req = 1; ifa.i_addr = 32'h44; ifa.mem_rdata = 32'h1111_2222;
        tick();
        chk("t5_fresh_addr", ifa.mem_addr, 32'h44);
        tick(); tick();
        chk("t5_fresh_ready", ifa.i_ready, 1'b1);
        chk("t5_fresh_rdata", ifa.i_rdata, 32'h1111_2222);
        ifa.i_req = 0;
        tick();

        // LATENCY=1 back-to-back fetches
        ifb.i_req = 1; ifb.i_addr = 32'h0; ifb.mem_rdata = 32'hA0;
        tick();
        chk("t6_en0", ifb.mem_enable, 1'b1);
        chk("t6_addr0", ifb.mem_addr, 32'h0);
        tick();
        chk("t6_en0_one_cycle", ifb.mem_enable, 1'b0);
        chk("t6_ready0", ifb.i_ready, 1'b1);
        chk("t6_rdata0", ifb.i_rdata, 32'hA0);
        ifb.i_addr = 32'h4; ifb.mem_rdata = 32'hA4;
        tick();
        chk("t6_no_dup_grant", {ifb.mem_enable, ifb.i_ready}, 2'b00);
        tick();
        chk("t6_en1", ifb.mem_enable, 1'b1);
        chk("t6_addr1", ifb.mem_addr, 32'h4);
        tick();
        chk("t6_ready1", {ifb.mem_enable, ifb.i_ready}, 2'b01);
        chk("t6_rdata1", ifb.i_rdata, 32'hA4);
        ifb.i_req = 0;
        tick();
        chk("t6_done", {ifb.busy, ifb.i_ready}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
